// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
//   Shared definitions for the common-data-bus arbiter:
//   - default sizing of the arbiter (units, tag width, result width)
//   - functional-unit indices used as requester / source numbers
//   - source-index width helper (keeps a 1-bit index for a single requester)
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int BW_TAG_DEF  = 4;
    localparam int BW_DATA_DEF = 32;

    // Requester index of each functional unit on the CDB.
    localparam int UNIT_INT        = 0;
    localparam int UNIT_MUL        = 1;
    localparam int UNIT_BRANCH     = 2;
    localparam int UNIT_LOAD_STORE = 3;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int src_width(input int n);
        return $clog2(n) + ((n <= 1) ? 1 : 0);
    endfunction

endpackage

// File: rtl/cdb_arbiter_round_robin_arbiter.sv
// -----------------------------------------------------------------------------
// round_robin_arbiter
//   Purely combinational round-robin picker. Starting at i_ptr and wrapping
//   modulo N, the first asserted request wins.
// Ports:
//   i_req        in   N   request vector
//   i_ptr        in   W   highest-priority index this cycle
//   o_grant      out  N   one-hot grant, all zero when nothing requests
//   o_grant_idx  out  W   index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module round_robin_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N = NUM_REQ_DEF,
    parameter int W = src_width(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_grant_idx
);

    logic         found;
    logic [W-1:0] idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        found       = 1'b0;
        idx         = '0;
        for (int off = 0; off < N; off++) begin
            idx = W'((int'(i_ptr) + off) % N);
            if (!found && i_req[idx]) begin
                found       = 1'b1;
                o_grant     = '0;
                o_grant[idx] = 1'b1;
                o_grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Schedules the common data bus among the functional units (INT, MUL,
//   BRANCH, LOAD_STORE). One result is granted per cycle, round-robin, and is
//   broadcast from a register on the following cycle. Speculative requesters
//   are masked out in a cycle where the branch unit reports a misprediction.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req_valid         per-unit result available
//   i_req_ready         per-unit accept (one-hot grant, combinational)
//   i_req_tag_flatten   per-unit rename tag, unit k at [k*BW_TAG +: BW_TAG]
//   i_req_data_flatten  per-unit signed result
//   i_req_speculation   per-unit result depends on an unresolved branch
//   i_branch_valid      branch resolved this cycle
//   i_branch_flush      resolved branch mispredicted (qualified by valid)
//   o_cdb_valid/tag/data/src  registered broadcast, no back-pressure
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ           = NUM_REQ_DEF,
    parameter int BW_TAG            = BW_TAG_DEF,
    parameter int BW_PROCESSOR_DATA = BW_DATA_DEF,
    parameter int BW_SRC            = $clog2(NUM_REQ) + ((NUM_REQ <= 1) ? 1 : 0)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     i_req_valid,
    output logic [NUM_REQ-1:0]                     i_req_ready,
    input  logic [NUM_REQ*BW_TAG-1:0]              i_req_tag_flatten,
    input  logic [NUM_REQ*BW_PROCESSOR_DATA-1:0]   i_req_data_flatten,
    input  logic [NUM_REQ-1:0]                     i_req_speculation,
    input  logic                                   i_branch_valid,
    input  logic                                   i_branch_flush,
    output logic                                   o_cdb_valid,
    output logic [BW_TAG-1:0]                      o_cdb_tag,
    output logic [BW_PROCESSOR_DATA-1:0]           o_cdb_data,
    output logic [BW_SRC-1:0]                      o_cdb_src
);

    logic                                flush;
    logic [NUM_REQ-1:0]                  elig;
    logic [NUM_REQ-1:0]                  grant;
    logic [BW_SRC-1:0]                   grant_idx;
    logic                                xfer;
    logic [BW_TAG-1:0]                   tag_sel;
    logic signed [BW_PROCESSOR_DATA-1:0] data_sel;
    logic [BW_SRC-1:0]                   ptr;

    logic                                vld_p1;
    logic [BW_TAG-1:0]                   tag_p1;
    logic signed [BW_PROCESSOR_DATA-1:0] data_p1;
    logic [BW_SRC-1:0]                   src_p1;

    // Stage p0: flush masking, round-robin grant, winner mux
    assign flush = i_branch_valid && i_branch_flush;
    assign elig  = i_req_valid & ~({NUM_REQ{flush}} & i_req_speculation);

    round_robin_arbiter #(
        .N (NUM_REQ),
        .W (BW_SRC)
    ) u_rr (
        .i_req       (elig),
        .i_ptr       (ptr),
        .o_grant     (grant),
        .o_grant_idx (grant_idx)
    );

    // A grant only lands on an eligible (hence valid) unit, so any grant is a transfer.
    assign i_req_ready = grant;
    assign xfer        = |grant;
    assign tag_sel     = i_req_tag_flatten[grant_idx*BW_TAG +: BW_TAG];
    assign data_sel    = $signed(i_req_data_flatten[grant_idx*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA]);

    // Stage p1: registered broadcast and priority pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            tag_p1  <= '0;
            data_p1 <= '0;
            src_p1  <= '0;
            ptr     <= '0;
        end else begin
            vld_p1 <= xfer;
            if (xfer) begin
                tag_p1  <= tag_sel;
                data_p1 <= data_sel;
                src_p1  <= grant_idx;
                ptr     <= (grant_idx == BW_SRC'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign o_cdb_valid = vld_p1;
    assign o_cdb_tag   = tag_p1;
    assign o_cdb_data  = data_p1;
    assign o_cdb_src   = src_p1;

    // Tag 0 means "value ready" and must never be put on the bus.
    a_no_tag_zero: assert property (@(posedge clk) disable iff (!rst_n)
                                    xfer |-> (tag_sel != '0));

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [15:0]  tag_flat;
    logic [127:0] data_flat;
    logic [3:0]   spec;
    logic         branch_valid;
    logic         branch_flush;
    logic         cdb_valid;
    logic [3:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic [1:0]   cdb_src;

    int total = 0;
    int bad   = 0;

    cdb_arbiter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_req_valid        (req_valid),
        .i_req_ready        (req_ready),
        .i_req_tag_flatten  (tag_flat),
        .i_req_data_flatten (data_flat),
        .i_req_speculation  (spec),
        .i_branch_valid     (branch_valid),
        .i_branch_flush     (branch_flush),
        .o_cdb_valid        (cdb_valid),
        .o_cdb_tag          (cdb_tag),
        .o_cdb_data         (cdb_data),
        .o_cdb_src          (cdb_src)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int k, input logic [3:0] t, input logic [31:0] d, input logic s);
        req_valid[k]         = 1'b1;
        tag_flat[k*4 +: 4]   = t;
        data_flat[k*32 +: 32] = d;
        spec[k]              = s;
    endtask

    task automatic clear_req();
        req_valid = '0;
        spec      = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; tag_flat = '0; data_flat = '0; spec = '0;
        branch_valid = 1'b0; branch_flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0b exp=0", cdb_valid); end
        total++; if (cdb_tag !== 4'd0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", cdb_tag); end
        total++; if (cdb_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%0h exp=0", cdb_data); end
        total++; if (cdb_src !== 2'd0) begin bad++; $display("FAIL reset_src got=%0d exp=0", cdb_src); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        total++; if (dut.ptr !== 2'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr); end
    endtask

    task automatic test_single_mul();
        set_req(1, 4'd3, 32'hFFFF_FFF9, 1'b0);
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mul_ready got=%b exp=0010", req_ready); end
        @(posedge clk); #1;
        clear_req();
        total++; if (cdb_valid !== 1'b1) begin bad++; $display("FAIL mul_vld got=%0b exp=1", cdb_valid); end
        total++; if (cdb_tag !== 4'd3) begin bad++; $display("FAIL mul_tag got=%0d exp=3", cdb_tag); end
        total++; if (cdb_data !== 32'hFFFF_FFF9) begin bad++; $display("FAIL mul_data got=%0h exp=fffffff9", cdb_data); end
        total++; if (cdb_src !== 2'd1) begin bad++; $display("FAIL mul_src got=%0d exp=1", cdb_src); end
        total++; if (dut.ptr !== 2'd2) begin bad++; $display("FAIL mul_ptr got=%0d exp=2", dut.ptr); end
        @(posedge clk); #1;
        total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL idle_vld got=%0b exp=0", cdb_valid); end
        total++; if (cdb_tag !== 4'd3 || cdb_src !== 2'd1 || cdb_data !== 32'hFFFF_FFF9)
            begin bad++; $display("FAIL idle_hold got=%0d/%0d/%0h exp=3/1/fffffff9", cdb_tag, cdb_src, cdb_data); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_r;
        logic [31:0] exp_d;
        // Restart from ptr=0 with an asynchronous reset pulse between edges.
        rst_n = 1'b0; #3; rst_n = 1'b1;
        for (int k = 0; k < 4; k++) set_req(k, 4'(k + 1), 32'(k * 100 - 200), 1'b0);
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_r = 4'b0001 << (c % 4);
            total++; if (req_ready !== exp_r) begin bad++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, req_ready, exp_r); end
            @(posedge clk); #1;
            exp_d = 32'((c % 4) * 100 - 200);
            total++; if (cdb_valid !== 1'b1 || cdb_src !== 2'(c % 4) || cdb_tag !== 4'(c % 4 + 1) || cdb_data !== exp_d)
                begin bad++; $display("FAIL b2b_cdb c=%0d got=%0b/%0d/%0d/%0h exp=1/%0d/%0d/%0h",
                                      c, cdb_valid, cdb_src, cdb_tag, cdb_data, c % 4, c % 4 + 1, exp_d); end
        end
        clear_req();
        total++; if (dut.ptr !== 2'd0) begin bad++; $display("FAIL b2b_ptr got=%0d exp=0", dut.ptr); end
    endtask

    task automatic test_ptr_wrap();
        set_req(1, 4'd2, 32'd11, 1'b0);
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wrap_pre_ready got=%b exp=0010", req_ready); end
        @(posedge clk); #1;
        total++; if (dut.ptr !== 2'd2) begin bad++; $display("FAIL wrap_pre_ptr got=%0d exp=2", dut.ptr); end
        set_req(1, 4'd4, 32'd22, 1'b0);
        set_req(3, 4'd8, 32'd33, 1'b0);
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_first_ready got=%b exp=1000", req_ready); end
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        total++; if (cdb_src !== 2'd3 || cdb_tag !== 4'd8) begin bad++; $display("FAIL wrap_first_cdb got=%0d/%0d exp=3/8", cdb_src, cdb_tag); end
        total++; if (dut.ptr !== 2'd0) begin bad++; $display("FAIL wrap_mid_ptr got=%0d exp=0", dut.ptr); end
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wrap_second_ready got=%b exp=0010", req_ready); end
        @(posedge clk); #1;
        clear_req();
        total++; if (cdb_src !== 2'd1 || cdb_tag !== 4'd4 || cdb_data !== 32'd22)
            begin bad++; $display("FAIL wrap_second_cdb got=%0d/%0d/%0h exp=1/4/16", cdb_src, cdb_tag, cdb_data); end
        total++; if (dut.ptr !== 2'd2) begin bad++; $display("FAIL wrap_end_ptr got=%0d exp=2", dut.ptr); end
    endtask

    task automatic test_flush();
        set_req(2, 4'd5, 32'd55, 1'b1);
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL flush_spec_ready got=%b exp=0100", req_ready); end
        @(posedge clk); #1;
        set_req(2, 4'd6, 32'd66, 1'b1);
        set_req(0, 4'd7, 32'hFFFF_FFFF, 1'b0);
        branch_valid = 1'b1; branch_flush = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL flush_ready got=%b exp=0001", req_ready); end
        total++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd2 || cdb_tag !== 4'd5)
            begin bad++; $display("FAIL flush_inflight got=%0b/%0d/%0d exp=1/2/5", cdb_valid, cdb_src, cdb_tag); end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        branch_valid = 1'b0;
        total++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_tag !== 4'd7 || cdb_data !== 32'hFFFF_FFFF)
            begin bad++; $display("FAIL flush_int_cdb got=%0b/%0d/%0d/%0h exp=1/0/7/ffffffff", cdb_valid, cdb_src, cdb_tag, cdb_data); end
        total++; if (dut.ptr !== 2'd1) begin bad++; $display("FAIL flush_ptr got=%0d exp=1", dut.ptr); end
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL unqual_flush_ready got=%b exp=0100", req_ready); end
        @(posedge clk); #1;
        clear_req();
        branch_flush = 1'b0;
        total++; if (cdb_src !== 2'd2 || cdb_tag !== 4'd6) begin bad++; $display("FAIL unqual_flush_cdb got=%0d/%0d exp=2/6", cdb_src, cdb_tag); end
    endtask

    task automatic test_reset_mid();
        set_req(0, 4'd9, 32'd99, 1'b0);
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_ready got=%b exp=0001", req_ready); end
        @(posedge clk); #1;
        clear_req();
        total++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd9) begin bad++; $display("FAIL rmid_pre got=%0b/%0d exp=1/9", cdb_valid, cdb_tag); end
        #2; rst_n = 1'b0; #1;
        total++; if (cdb_valid !== 1'b0 || cdb_tag !== 4'd0 || cdb_data !== 32'd0 || cdb_src !== 2'd0)
            begin bad++; $display("FAIL rmid_out got=%0b/%0d/%0h/%0d exp=0/0/0/0", cdb_valid, cdb_tag, cdb_data, cdb_src); end
        total++; if (dut.ptr !== 2'd0) begin bad++; $display("FAIL rmid_ptr got=%0d exp=0", dut.ptr); end
        #3; rst_n = 1'b1;
        for (int k = 0; k < 4; k++) set_req(k, 4'(k + 1), 32'(k + 1), 1'b0);
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_first_ready got=%b exp=0001", req_ready); end
        @(posedge clk); #1;
        clear_req();
        total++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_tag !== 4'd1)
            begin bad++; $display("FAIL rmid_first_cdb got=%0b/%0d/%0d exp=1/0/1", cdb_valid, cdb_src, cdb_tag); end
    endtask

    initial begin
        test_reset();
        test_single_mul();
        test_back_to_back();
        test_ptr_wrap();
        test_flush();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
